// File: rtl/pe_filter_prefetch_if.sv
// Filter-fetch bundle between the filter buffer, the controller and conv_pe.
// master = the sequencer, slave = its environment.
interface pe_filter_prefetch_if #(
    parameter int W_TIN     = 2,
    parameter int W_CHANNEL = 8,
    parameter int FB_AW     = 12
);
    logic                 i_csync_run;
    logic [W_CHANNEL-1:0] i_q_channel;
    logic                 i_fb_req_possible;
    logic                 i_swap;
    logic                 o_fb_req;
    logic [FB_AW-1:0]     o_fb_addr;
    logic                 o_load_vld;
    logic [W_TIN-1:0]     o_load_idx;
    logic                 o_load_bank;
    logic                 o_active_bank;
    logic                 o_csync_done;
    logic                 o_stall;
    logic                 o_err_swap;

    modport master (
        input  i_csync_run, i_q_channel, i_fb_req_possible, i_swap,
        output o_fb_req, o_fb_addr, o_load_vld, o_load_idx, o_load_bank,
               o_active_bank, o_csync_done, o_stall, o_err_swap
    );

    modport slave (
        output i_csync_run, i_q_channel, i_fb_req_possible, i_swap,
        input  o_fb_req, o_fb_addr, o_load_vld, o_load_idx, o_load_bank,
               o_active_bank, o_csync_done, o_stall, o_err_swap
    );
endinterface

// File: rtl/pe_filter_prefetch.sv
// Filter-fetch sequencer: bursts TIN filter words into one of NB_BANK banks,
// prefetching the shadow bank so a filter change is a bank swap.
module pe_filter_prefetch #(
    parameter int TIN       = 4,
    parameter int W_TIN     = 2,
    parameter int W_CHANNEL = 8,
    parameter int FB_AW     = 12,
    parameter int FB_DELAY  = 1,
    parameter int NB_BANK   = 2
) (
    input  logic clk,
    input  logic rstn,
    pe_filter_prefetch_if.master bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                         state_q, state_d;
    logic                           csync_q;
    logic [W_TIN-1:0]               offset_q, offset_d;
    logic [W_CHANNEL-1:0]           fidx_q, fidx_d;
    logic [1:0]                     loaded_q, loaded_d;
    logic [1:0]                     pend_q, pend_d;
    logic                           active_q, active_d;
    logic                           target_q, target_d;
    logic                           err_q, err_d;
    logic [FB_DELAY-1:0]            pv_q, pv_d;
    logic [FB_DELAY-1:0][W_TIN-1:0] pidx_q, pidx_d;
    logic [FB_DELAY-1:0]            pbank_q, pbank_d;

    logic                 csync_start, fb_req, last_word, load_done;
    logic                 tgt_ok, tgt_bank;
    logic [1:0]           free;
    logic [W_CHANNEL-1:0] q_last;

    assign csync_start = bus.i_csync_run & ~csync_q;
    assign fb_req      = (state_q == BURST);
    assign last_word   = (offset_q == W_TIN'(TIN - 1));
    assign load_done   = pv_q[FB_DELAY-1] & (pidx_q[FB_DELAY-1] == W_TIN'(TIN - 1));
    assign q_last      = (bus.i_q_channel == '0) ? '0 : bus.i_q_channel - W_CHANNEL'(1);
    // A bank already being fetched is not a candidate again until it completes.
    assign free        = ~loaded_q & ~pend_q;

    always_comb begin
        tgt_ok   = 1'b0;
        tgt_bank = active_q;
        if (free[active_q]) begin
            tgt_ok = 1'b1;
        end else if (NB_BANK == 2 && free[~active_q]) begin
            tgt_ok   = 1'b1;
            tgt_bank = ~active_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        fidx_d   = fidx_q;
        loaded_d = loaded_q;
        pend_d   = pend_q;
        active_d = active_q;
        target_d = target_q;
        err_d    = err_q;

        // stage p0 -> p(FB_DELAY): request strobe travels with its lane and bank
        pv_d[0]    = fb_req;
        pidx_d[0]  = offset_q;
        pbank_d[0] = target_q;
        for (int i = 1; i < FB_DELAY; i++) begin
            pv_d[i]    = pv_q[i-1];
            pidx_d[i]  = pidx_q[i-1];
            pbank_d[i] = pbank_q[i-1];
        end

        if (load_done) begin
            loaded_d[pbank_q[FB_DELAY-1]] = 1'b1;
            pend_d[pbank_q[FB_DELAY-1]]   = 1'b0;
        end

        // Swap sees this cycle's completing load, so load-then-clear ordering holds.
        if (bus.i_swap) begin
            if (loaded_d[active_q]) begin
                loaded_d[active_q] = 1'b0;
                if (NB_BANK == 2) active_d = ~active_q;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tgt_ok && bus.i_fb_req_possible) begin
                    state_d          = BURST;
                    target_d         = tgt_bank;
                    pend_d[tgt_bank] = 1'b1;
                    offset_d         = '0;
                end
            end
            BURST: begin
                offset_d = offset_q + W_TIN'(1);
                if (last_word) begin
                    offset_d = '0;
                    fidx_d   = (fidx_q >= q_last) ? '0 : fidx_q + W_CHANNEL'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (csync_start) begin
            state_d  = IDLE;
            offset_d = '0;
            fidx_d   = '0;
            loaded_d = '0;
            pend_d   = '0;
            active_d = 1'b0;
            target_d = 1'b0;
            pv_d     = '0;
            pidx_d   = '0;
            pbank_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            csync_q  <= 1'b0;
            offset_q <= '0;
            fidx_q   <= '0;
            loaded_q <= '0;
            pend_q   <= '0;
            active_q <= 1'b0;
            target_q <= 1'b0;
            err_q    <= 1'b0;
            pv_q     <= '0;
            pidx_q   <= '0;
            pbank_q  <= '0;
        end else begin
            state_q  <= state_d;
            csync_q  <= bus.i_csync_run;
            offset_q <= offset_d;
            fidx_q   <= fidx_d;
            loaded_q <= loaded_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            target_q <= target_d;
            err_q    <= err_d;
            pv_q     <= pv_d;
            pidx_q   <= pidx_d;
            pbank_q  <= pbank_d;
        end
    end

    assign bus.o_fb_req      = fb_req;
    assign bus.o_fb_addr     = FB_AW'(32'(fidx_q) * 32'(TIN) + 32'(offset_q));
    assign bus.o_load_vld    = pv_q[FB_DELAY-1];
    assign bus.o_load_idx    = pidx_q[FB_DELAY-1];
    assign bus.o_load_bank   = pbank_q[FB_DELAY-1];
    assign bus.o_active_bank = active_q;
    assign bus.o_csync_done  = bus.i_csync_run & loaded_q[active_q];
    // Held low while reset is asserted so every output reads 0 in reset.
    assign bus.o_stall       = rstn & ~bus.i_csync_run & ~loaded_q[active_q];
    assign bus.o_err_swap    = err_q;
endmodule

// File: tb/tb_pe_filter_prefetch.sv
// Bench for pe_filter_prefetch: a cycle table for the first burst, a request/load
// scoreboard on the ping-pong instance, and hand sequences for swaps, abort and reset.
`timescale 1ns/1ps
module tb_pe_filter_prefetch;
    localparam int TIN = 4, W_TIN = 2, W_CHANNEL = 8, FB_AW = 12, FB_DELAY = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_filter_prefetch_if #(.W_TIN(W_TIN), .W_CHANNEL(W_CHANNEL), .FB_AW(FB_AW)) bus2 ();
    pe_filter_prefetch_if #(.W_TIN(W_TIN), .W_CHANNEL(W_CHANNEL), .FB_AW(FB_AW)) bus1 ();

    pe_filter_prefetch #(.TIN(TIN), .W_TIN(W_TIN), .W_CHANNEL(W_CHANNEL), .FB_AW(FB_AW),
                         .FB_DELAY(FB_DELAY), .NB_BANK(2))
        dut2 (.clk(clk), .rstn(rstn), .bus(bus2));
    pe_filter_prefetch #(.TIN(TIN), .W_TIN(W_TIN), .W_CHANNEL(W_CHANNEL), .FB_AW(FB_AW),
                         .FB_DELAY(FB_DELAY), .NB_BANK(1))
        dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    typedef struct {
        logic [FB_AW-1:0] addr;
        logic [W_TIN-1:0] idx;
        logic             bank;
    } req_t;
    typedef struct {
        logic [W_TIN-1:0] idx;
        logic             bank;
        int               stamp;
    } ld_t;
    typedef struct {
        logic run, rp, swap;
        logic fb_req;
        logic [FB_AW-1:0] addr;
        logic lv;
        logic [W_TIN-1:0] idx;
        logic done, stall, active;
    } vec_t;

    req_t exp_q[$];
    ld_t  ld_q[$];
    vec_t tbl[8];

    function automatic vec_t mk(input int run, input int rp, input int sw, input int fb,
                                input int addr, input int lv, input int idx,
                                input int done, input int stall, input int act);
        vec_t v;
        v.run = run[0]; v.rp = rp[0]; v.swap = sw[0]; v.fb_req = fb[0];
        v.addr = FB_AW'(addr); v.lv = lv[0]; v.idx = W_TIN'(idx);
        v.done = done[0]; v.stall = stall[0]; v.active = act[0];
        return v;
    endfunction

    task automatic push_burst(input int base, input int nwords, input int bank);
        req_t r;
        for (int i = 0; i < nwords; i++) begin
            r.addr = FB_AW'(base + i);
            r.idx  = W_TIN'(i);
            r.bank = bank[0];
            exp_q.push_back(r);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard on the ping-pong instance: requests in order, loads FB_DELAY later.
    always @(negedge clk) begin
        req_t r;
        ld_t  l;
        if (bus2.o_load_vld) begin
            if (ld_q.size() == 0) fail("unexpected_load_vld");
            else begin
                l = ld_q.pop_front();
                check("load_idx", 32'(bus2.o_load_idx), 32'(l.idx));
                check("load_bank", 32'(bus2.o_load_bank), 32'(l.bank));
                check("load_latency", 32'(cyc - l.stamp), 32'(FB_DELAY));
            end
        end
        if (bus2.o_fb_req) begin
            if (exp_q.size() == 0) fail("unexpected_fb_req");
            else begin
                r = exp_q.pop_front();
                check("fb_addr", 32'(bus2.o_fb_addr), 32'(r.addr));
                l.idx = r.idx; l.bank = r.bank; l.stamp = cyc;
                ld_q.push_back(l);
            end
        end
    end

    int rel = 0;
    task automatic step();
        @(posedge clk);
        #1;
        rel++;
    endtask
    task automatic goto(input int n);
        while (rel < n) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fb_req"}, 32'(bus2.o_fb_req), 0);
        check({tag, "_fb_addr"}, 32'(bus2.o_fb_addr), 0);
        check({tag, "_load_vld"}, 32'(bus2.o_load_vld), 0);
        check({tag, "_load_idx"}, 32'(bus2.o_load_idx), 0);
        check({tag, "_load_bank"}, 32'(bus2.o_load_bank), 0);
        check({tag, "_active"}, 32'(bus2.o_active_bank), 0);
        check({tag, "_done"}, 32'(bus2.o_csync_done), 0);
        check({tag, "_stall"}, 32'(bus2.o_stall), 0);
        check({tag, "_err_swap"}, 32'(bus2.o_err_swap), 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        logic exp_fb, exp_lv;

        tbl[0] = mk(1,1,0, 0,0, 0,0, 0,0,0);
        tbl[1] = mk(1,1,0, 0,0, 0,0, 0,0,0);
        tbl[2] = mk(1,1,0, 1,0, 0,0, 0,0,0);
        tbl[3] = mk(1,1,0, 1,1, 1,0, 0,0,0);
        tbl[4] = mk(1,1,0, 1,2, 1,1, 0,0,0);
        tbl[5] = mk(1,1,0, 1,3, 1,2, 0,0,0);
        tbl[6] = mk(1,1,0, 0,0, 1,3, 0,0,0);
        tbl[7] = mk(1,1,0, 1,4, 0,0, 1,0,0);

        push_burst(0, 4, 0);
        push_burst(4, 4, 1);
        push_burst(8, 4, 0);
        push_burst(0, 4, 1);
        push_burst(4, 4, 0);
        push_burst(8, 3, 1);
        push_burst(0, 4, 0);
        push_burst(4, 1, 1);

        bus2.i_csync_run = 0; bus2.i_q_channel = 3; bus2.i_fb_req_possible = 0; bus2.i_swap = 0;
        bus1.i_csync_run = 0; bus1.i_q_channel = 0; bus1.i_fb_req_possible = 0; bus1.i_swap = 0;

        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_stall", 32'(bus2.o_stall), 1);

        @(posedge clk);
        #1;
        rel = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            bus2.i_csync_run       = tbl[i].run;
            bus2.i_fb_req_possible = tbl[i].rp;
            bus2.i_swap            = tbl[i].swap;
            @(negedge clk);
            check($sformatf("tbl%0d_fb_req", i), 32'(bus2.o_fb_req), 32'(tbl[i].fb_req));
            if (tbl[i].fb_req) check($sformatf("tbl%0d_addr", i), 32'(bus2.o_fb_addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_load_vld", i), 32'(bus2.o_load_vld), 32'(tbl[i].lv));
            if (tbl[i].lv) check($sformatf("tbl%0d_load_idx", i), 32'(bus2.o_load_idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d_done", i), 32'(bus2.o_csync_done), 32'(tbl[i].done));
            check($sformatf("tbl%0d_stall", i), 32'(bus2.o_stall), 32'(tbl[i].stall));
            check($sformatf("tbl%0d_active", i), 32'(bus2.o_active_bank), 32'(tbl[i].active));
        end

        goto(8);  bus2.i_csync_run = 0;
        @(negedge clk); check("c8_stall", 32'(bus2.o_stall), 0);
        goto(14); bus2.i_swap = 1;
        goto(15); bus2.i_swap = 0;
        @(negedge clk);
        check("swap1_active", 32'(bus2.o_active_bank), 1);
        check("swap1_stall", 32'(bus2.o_stall), 0);
        goto(22); bus2.i_swap = 1;
        goto(23); bus2.i_swap = 0;
        @(negedge clk); check("swap2_active", 32'(bus2.o_active_bank), 0);
        goto(28); bus2.i_swap = 1;
        @(negedge clk);
        check("simul_load_vld", 32'(bus2.o_load_vld), 1);
        check("simul_load_idx", 32'(bus2.o_load_idx), 3);
        check("simul_load_bank", 32'(bus2.o_load_bank), 1);
        check("simul_stall_c28", 32'(bus2.o_stall), 0);
        goto(29); bus2.i_swap = 0;
        @(negedge clk);
        check("simul_active", 32'(bus2.o_active_bank), 1);
        check("simul_stall_c29", 32'(bus2.o_stall), 0);
        goto(30); bus2.i_swap = 1;
        goto(31);
        @(negedge clk);
        check("swap4_active", 32'(bus2.o_active_bank), 0);
        check("swap4_stall", 32'(bus2.o_stall), 1);
        check("err_before", 32'(bus2.o_err_swap), 0);
        goto(32); bus2.i_swap = 0;
        @(negedge clk);
        check("err_set", 32'(bus2.o_err_swap), 1);
        check("err_active_kept", 32'(bus2.o_active_bank), 0);
        check("err_stall", 32'(bus2.o_stall), 1);
        goto(35);
        @(negedge clk);
        check("refill_stall", 32'(bus2.o_stall), 0);
        check("err_sticky", 32'(bus2.o_err_swap), 1);

        goto(37); bus2.i_csync_run = 1;
        @(negedge clk); check("abort_fb_req_c37", 32'(bus2.o_fb_req), 1);
        goto(38); ld_q.delete();
        @(negedge clk);
        check("abort_fb_req_c38", 32'(bus2.o_fb_req), 0);
        check("abort_load_vld", 32'(bus2.o_load_vld), 0);
        check("abort_load_idx", 32'(bus2.o_load_idx), 0);
        check("abort_active", 32'(bus2.o_active_bank), 0);
        check("abort_err_kept", 32'(bus2.o_err_swap), 1);
        goto(43); bus2.i_fb_req_possible = 0;
        goto(44);
        @(negedge clk); check("restart_done", 32'(bus2.o_csync_done), 1);
        for (int c = 45; c < 60; c++) begin
            goto(c);
            @(negedge clk);
            check($sformatf("hold_idle_c%0d", c), 32'(bus2.o_fb_req), 0);
        end

        goto(60); bus2.i_fb_req_possible = 1;
        goto(62); bus2.i_fb_req_possible = 0; bus2.i_csync_run = 0;
        #2 rstn = 1'b0;
        #1;
        check_zero("async_rst");
        check("exp_q_drained", 32'(exp_q.size()), 0);
        ld_q.delete();
        goto(64); rstn = 1'b1;
        goto(74);
        @(negedge clk);
        check("post_rst_stall", 32'(bus2.o_stall), 1);
        check("post_rst_no_req", 32'(exp_q.size() + ld_q.size()), 0);

        @(posedge clk);
        #1;
        rel = 0;
        stall_cnt = 0;
        bus1.i_csync_run = 1; bus1.i_fb_req_possible = 1; bus1.i_q_channel = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            if (c == 8)  bus1.i_csync_run = 0;
            if (c == 10) bus1.i_swap = 1;
            if (c == 11) bus1.i_swap = 0;
            @(negedge clk);
            exp_fb = (c >= 2 && c <= 5) || (c >= 12 && c <= 15);
            exp_lv = (c >= 3 && c <= 6) || (c >= 13 && c <= 16);
            check($sformatf("sb_c%0d_fb_req", c), 32'(bus1.o_fb_req), 32'(exp_fb));
            if (exp_fb) check($sformatf("sb_c%0d_addr", c), 32'(bus1.o_fb_addr), (c <= 5) ? c - 2 : c - 12);
            check($sformatf("sb_c%0d_load_vld", c), 32'(bus1.o_load_vld), 32'(exp_lv));
            check($sformatf("sb_c%0d_stall", c), 32'(bus1.o_stall), (c >= 11 && c <= 16) ? 1 : 0);
            check($sformatf("sb_c%0d_active", c), 32'(bus1.o_active_bank), 0);
            if (bus1.o_stall) stall_cnt++;
        end
        check("sb_stall_cycles", 32'(stall_cnt), TIN + FB_DELAY + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
